// File: rtl/lfsr_sampler_if.sv
// Signal bundle between the LFSR source, the board pins and lfsr_sampler.
// The sampler sits on the slave side; the driver of rnd_in/btn/auto_en is the master.
interface lfsr_sampler_if #(
    parameter int NBIT = 8
);
    logic [NBIT-1:0] rnd_in;
    logic            btn;
    logic            auto_en;
    logic [NBIT-1:0] sample;
    logic [7:0]      sample_cnt;
    logic [7:0]      seg_hi;
    logic [7:0]      seg_lo;
    logic            lock_err;
    logic            miss;

    modport master (
        output rnd_in, btn, auto_en,
        input  sample, sample_cnt, seg_hi, seg_lo, lock_err, miss
    );

    modport slave (
        input  rnd_in, btn, auto_en,
        output sample, sample_cnt, seg_hi, seg_lo, lock_err, miss
    );
endinterface

// File: rtl/lfsr_sampler.sv
// Captures the LFSR word on a debounced key press or periodic tick and shows the
// low byte on two active-low 7-segment digits; flags all-zero captures and dropped triggers.

module hex7seg (
    input  logic [3:0] nib,
    output logic [7:0] seg
);
    // {dp,g,f,e,d,c,b,a}, 0 = lit, dp held off
    always_comb begin
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end
endmodule

module lfsr_sampler #(
    parameter int NBIT  = 8,
    parameter int DIV_W = 24
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_sampler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPT, WAIT_REL} state_t;

    state_t            state, state_nxt;
    logic [3:1]        bsync;
    logic [DIV_W-1:0]  div;
    logic [NBIT-1:0]   sample;
    logic [7:0]        cnt;
    logic [7:0]        seg_hi, seg_lo;
    logic              lock_err, miss;
    logic              man_trig, auto_trig, trig;
    logic              cap, drop;
    logic [1:0][7:0]   seg_nxt;

    // bsync[1] absorbs metastability; a press is a rising edge seen between bsync[2] and bsync[3]
    assign man_trig  = bsync[2] & ~bsync[3];
    assign auto_trig = bus.auto_en & (div == {DIV_W{1'b1}});
    assign trig      = man_trig | auto_trig;

    for (genvar d = 0; d < 2; d++) begin : g_dig
        hex7seg u_hex (
            .nib (sample[4*d +: 4]),
            .seg (seg_nxt[d])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    cap       = 1'b1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                drop      = trig;
                state_nxt = bsync[2] ? WAIT_REL : IDLE;
            end
            WAIT_REL: begin
                drop = trig;
                if (!bsync[2]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bsync    <= '0;
            div      <= '0;
            sample   <= '0;
            cnt      <= '0;
            seg_hi   <= 8'hFF;
            seg_lo   <= 8'hFF;
            lock_err <= 1'b0;
            miss     <= 1'b0;
        end else begin
            bsync <= {bsync[2:1], bus.btn};
            div   <= bus.auto_en ? div + DIV_W'(1) : '0;
            if (cap) begin
                sample   <= bus.rnd_in;
                cnt      <= cnt + 8'd1;
                lock_err <= (bus.rnd_in == '0);
            end
            // digits follow the capture by one cycle, decoded from the registered sample
            if (state == CAPT) begin
                seg_hi <= seg_nxt[1];
                seg_lo <= seg_nxt[0];
            end
            if (drop) miss <= 1'b1;
        end
    end

    assign bus.sample     = sample;
    assign bus.sample_cnt = cnt;
    assign bus.seg_hi     = seg_hi;
    assign bus.seg_lo     = seg_lo;
    assign bus.lock_err   = lock_err;
    assign bus.miss       = miss;
endmodule

// File: tb/tb_lfsr_sampler.sv
// Bench for lfsr_sampler: directed scenarios with literal expectations, then random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_lfsr_sampler;
    localparam int NBIT  = 10;
    localparam int DIV_W = 4;
    localparam int PER   = 1 << DIV_W;

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_sampler_if #(.NBIT(NBIT)) bus ();

    lfsr_sampler #(.NBIT(NBIT), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // btn_seen[i] = btn value sampled i+1 edges ago; auto_run = consecutive edges with auto_en=1.
    logic [NBIT-1:0] m_sample = '0;
    logic [7:0]      m_cnt = 8'd0, m_hi = 8'hFF, m_lo = 8'hFF;
    bit              m_lock = 0, m_miss = 0;
    bit              btn_seen [3] = '{0, 0, 0};
    int              auto_run = 0;
    bit              seg_due = 0;   // a capture happened at the previous edge
    bit              hold = 0;      // key still down after a capture; block until released

    always @(posedge clk) begin
        bit pressed, tick_now, trig, fire, key_down;
        if (!rst) begin
            m_sample = '0; m_cnt = 0; m_hi = 8'hFF; m_lo = 8'hFF;
            m_lock = 0; m_miss = 0; btn_seen = '{0, 0, 0};
            auto_run = 0; seg_due = 0; hold = 0;
        end else begin
            key_down = btn_seen[1];
            pressed  = btn_seen[1] && !btn_seen[2];
            tick_now = bus.auto_en && ((auto_run % PER) == PER - 1);
            trig     = pressed || tick_now;
            fire     = trig && !seg_due && !hold;
            if (trig && !fire) m_miss = 1;
            if (seg_due) begin
                m_hi    = HEX[m_sample[7:4]];
                m_lo    = HEX[m_sample[3:0]];
                hold    = key_down;
                seg_due = 0;
            end else if (hold) begin
                hold = key_down;
            end
            if (fire) begin
                m_sample = bus.rnd_in;
                m_cnt    = m_cnt + 8'd1;
                m_lock   = (bus.rnd_in == 0);
                seg_due  = 1;
            end
            auto_run    = bus.auto_en ? auto_run + 1 : 0;
            btn_seen[2] = btn_seen[1];
            btn_seen[1] = btn_seen[0];
            btn_seen[0] = bus.btn;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("sample",     bus.sample,     m_sample);
            check("sample_cnt", bus.sample_cnt, m_cnt);
            check("seg_hi",     bus.seg_hi,     m_hi);
            check("seg_lo",     bus.seg_lo,     m_lo);
            check("lock_err",   bus.lock_err,   m_lock);
            check("miss",       bus.miss,       m_miss);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.rnd_in  = '0;
        bus.btn     = 1'b1;
        bus.auto_en = 1'b1;
        rst         = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("rst_sample", bus.sample, 0);
        check("rst_cnt",    bus.sample_cnt, 0);
        check("rst_seg_hi", bus.seg_hi, 8'hFF);
        check("rst_seg_lo", bus.seg_lo, 8'hFF);
        check("rst_lock",   bus.lock_err, 0);
        check("rst_miss",   bus.miss, 0);
        rst = 1'b1; bus.btn = 1'b0; bus.auto_en = 1'b0;
        tick(4);

        // manual capture, latency k+2 / k+3
        bus.rnd_in = 10'h0A5; bus.btn = 1'b1;
        tick(3);
        check("man_sample", bus.sample, 10'h0A5);
        check("man_cnt",    bus.sample_cnt, 1);
        check("man_seg_early", bus.seg_hi, 8'hFF);
        tick(1);
        check("man_seg_hi", bus.seg_hi, 8'h88);
        check("man_seg_lo", bus.seg_lo, 8'h92);
        tick(6);
        check("man_held_cnt", bus.sample_cnt, 1);
        bus.btn = 1'b0;
        tick(4);

        // re-press
        bus.rnd_in = 10'h03C; bus.btn = 1'b1;
        tick(4);
        check("re_cnt",    bus.sample_cnt, 2);
        check("re_seg_hi", bus.seg_hi, 8'hB0);
        check("re_seg_lo", bus.seg_lo, 8'hC6);
        check("re_miss",   bus.miss, 0);
        bus.btn = 1'b0;
        tick(4);

        // auto mode: ticks at edges 16, 32, 48
        bus.rnd_in = 10'h15A; bus.auto_en = 1'b1;
        tick(48);
        check("auto_cnt", bus.sample_cnt, 5);
        tick(1);
        check("auto_seg_hi", bus.seg_hi, 8'h92);
        check("auto_seg_lo", bus.seg_lo, 8'h88);
        bus.auto_en = 1'b0;
        tick(40);
        check("auto_off_cnt", bus.sample_cnt, 5);

        // manual trigger coinciding with auto tick at edge 16, then auto tick in WAIT_REL
        bus.auto_en = 1'b1;
        tick(13);
        bus.btn = 1'b1; bus.rnd_in = 10'h2C3;
        tick(3);
        check("coll_cnt",    bus.sample_cnt, 6);
        check("coll_sample", bus.sample, 10'h2C3);
        check("coll_miss0",  bus.miss, 0);
        tick(17);
        check("wait_miss", bus.miss, 1);
        check("wait_cnt",  bus.sample_cnt, 6);
        bus.btn = 1'b0; bus.auto_en = 1'b0;
        tick(20);
        check("miss_sticky", bus.miss, 1);

        // lock-up word and recovery
        bus.rnd_in = '0; bus.btn = 1'b1;
        tick(4);
        check("lock_set",   bus.lock_err, 1);
        check("lock_hi",    bus.seg_hi, 8'hC0);
        check("lock_lo",    bus.seg_lo, 8'hC0);
        bus.btn = 1'b0; tick(4);
        bus.rnd_in = 10'h001; bus.btn = 1'b1;
        tick(4);
        check("lock_clr",   bus.lock_err, 0);
        check("one_lo",     bus.seg_lo, 8'hF9);
        bus.btn = 1'b0; tick(4);
        bus.rnd_in = 10'h100; bus.btn = 1'b1;
        tick(4);
        check("hi_bits_lock", bus.lock_err, 0);
        check("hi_bits_seg",  bus.seg_lo, 8'hC0);
        bus.btn = 1'b0; tick(4);

        // counter wrap after 255 captures
        rst = 1'b0; tick(1); rst = 1'b1;
        check("rst_clr_miss", bus.miss, 0);
        bus.rnd_in = 10'h0FF; bus.auto_en = 1'b1;
        tick(255 * PER);
        check("cnt_255", bus.sample_cnt, 8'hFF);
        tick(PER);
        check("cnt_wrap", bus.sample_cnt, 0);
        bus.auto_en = 1'b0;
        tick(3);

        // reset while in CAPT
        bus.rnd_in = 10'h077; bus.btn = 1'b1;
        tick(3);
        check("capt_sample", bus.sample, 10'h077);
        rst = 1'b0; tick(1);
        check("capt_rst_sample", bus.sample, 0);
        check("capt_rst_seg",    bus.seg_lo, 8'hFF);
        check("capt_rst_cnt",    bus.sample_cnt, 0);
        rst = 1'b1; bus.btn = 1'b0;
        tick(4);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            bus.rnd_in = ($urandom_range(0, 7) == 0) ? '0 : NBIT'($urandom);
            if ($urandom_range(0, 9) == 0)   bus.btn = ~bus.btn;
            if ($urandom_range(0, 149) == 0) bus.auto_en = ~bus.auto_en;
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        rst = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
